// File: rtl/multi_push_multi_pop_fifo_v2.sv
// Multi-lane show-ahead FIFO: up to NI words in and NO words out per cycle,
// arbitrary depth, occupancy/threshold status, sticky request-error flags
// and a synchronous flush.

// Per-lane storage index: (base + OFS) wrapped once modulo D.
// base < D and OFS < D, so the sum stays below 2*D and one subtraction wraps it.
module multi_push_multi_pop_fifo_v2_lane #(
    parameter int D   = 16,
    parameter int IW  = 4,
    parameter int OFS = 0
) (
    input  logic [IW-1:0] base,
    output logic [IW-1:0] idx
);
    localparam int AW = $clog2(D + 1) + 1;

    logic [AW-1:0] sum;

    // Add the lane offset and fold back into 0..D-1
    always_comb begin
        sum = AW'(base) + AW'(OFS);
        idx = (sum >= AW'(D)) ? IW'(sum - AW'(D)) : IW'(sum);
    end
endmodule

module multi_push_multi_pop_fifo_v2 #(
    parameter int W        = 16,
    parameter int D        = 16,
    parameter int NI       = 2,
    parameter int NO       = 2,
    parameter int AF_LEVEL = D - 1,
    parameter int AE_LEVEL = 1,
    localparam int PW      = $clog2(NI + 1),
    localparam int QW      = $clog2(NO + 1),
    localparam int CW      = $clog2(D + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [PW-1:0]          push,
    input  logic [NI-1:0][W-1:0]   push_data,
    input  logic [QW-1:0]          pop,
    output logic [NO-1:0][W-1:0]   pop_data,
    output logic [NO-1:0]          pop_valid,
    output logic [PW-1:0]          can_push,
    output logic [QW-1:0]          can_pop,
    output logic [CW-1:0]          count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);
    // One extra bit over the count width so sums of pointer + amount never truncate
    localparam int AW = CW + 1;
    localparam int IW = $clog2(D);

    logic [IW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ;
    logic [W-1:0]          mem [D];

    logic [NI-1:0][IW-1:0] wr_idx;
    logic [NO-1:0][IW-1:0] rd_idx;

    logic [AW-1:0]         space, cp_w, cpo_w, push_w, pop_w;
    logic [AW-1:0]         acc_push, acc_pop, wr_sum, rd_sum, occ_nxt;
    logic [IW-1:0]         wr_nxt, rd_nxt;
    logic                  ovf_set, udf_set;

    // Grant amounts from start-of-cycle occupancy, clamp requests, advance pointers
    always_comb begin
        space    = AW'(D) - AW'(occ);
        cp_w     = (space > AW'(NI)) ? AW'(NI) : space;
        cpo_w    = (AW'(occ) > AW'(NO)) ? AW'(NO) : AW'(occ);
        push_w   = AW'(push);
        pop_w    = AW'(pop);
        acc_push = (push_w > cp_w) ? cp_w : push_w;
        acc_pop  = (pop_w > cpo_w) ? cpo_w : pop_w;
        // A flush swallows the cycle's requests, including their error reports
        ovf_set  = !flush && (push_w > cp_w);
        udf_set  = !flush && (pop_w > cpo_w);
        wr_sum   = AW'(wr_ptr) + acc_push;
        rd_sum   = AW'(rd_ptr) + acc_pop;
        wr_nxt   = (wr_sum >= AW'(D)) ? IW'(wr_sum - AW'(D)) : IW'(wr_sum);
        rd_nxt   = (rd_sum >= AW'(D)) ? IW'(rd_sum - AW'(D)) : IW'(rd_sum);
        // acc_pop <= occ, so this never goes negative
        occ_nxt  = AW'(occ) + acc_push - acc_pop;
    end

    // Pointer, occupancy and sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                wr_ptr <= wr_nxt;
                rd_ptr <= rd_nxt;
                occ    <= CW'(occ_nxt);
            end
            // A fresh error beats a simultaneous clear
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= udf_set | (underflow & ~err_clr);
        end
    end

    // Write lane addresses: wr_ptr + i, mod D
    for (genvar i = 0; i < NI; i++) begin : g_wr
        multi_push_multi_pop_fifo_v2_lane #(.D(D), .IW(IW), .OFS(i)) u_idx (
            .base (wr_ptr),
            .idx  (wr_idx[i])
        );
    end

    // Read lanes: show-ahead data at rd_ptr + j, valid while j is below occupancy
    for (genvar j = 0; j < NO; j++) begin : g_rd
        multi_push_multi_pop_fifo_v2_lane #(.D(D), .IW(IW), .OFS(j)) u_idx (
            .base (rd_ptr),
            .idx  (rd_idx[j])
        );
        assign pop_data[j]  = mem[rd_idx[j]];
        assign pop_valid[j] = (j < int'(occ));
    end

    // Storage is not reset; only accepted lanes are written, nothing under flush
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < NI; i++) begin
                if (AW'(i) < acc_push) mem[wr_idx[i]] <= push_data[i];
            end
        end
    end

    assign count        = occ;
    assign can_push     = PW'(cp_w);
    assign can_pop      = QW'(cpo_w);
    assign almost_full  = (int'(occ) >= AF_LEVEL);
    assign almost_empty = (int'(occ) <= AE_LEVEL);
endmodule

// File: tb/tb_multi_push_multi_pop_fifo_v2.sv
// Bench for multi_push_multi_pop_fifo_v2 with W=8, D=5, NI=3, NO=2, AF=4, AE=1.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_multi_push_multi_pop_fifo_v2;
    localparam int W = 8, D = 5, NI = 3, NO = 2;

    logic                 clk = 1'b0, rst = 1'b1, flush = 1'b0, err_clr = 1'b0;
    logic [1:0]           push = '0, pop = '0;
    logic [NI-1:0][W-1:0] push_data = '0;
    logic [NO-1:0][W-1:0] pop_data;
    logic [1:0]           pop_valid, can_push, can_pop;
    logic [2:0]           count;
    logic                 almost_full, almost_empty, overflow, underflow;

    int nvec = 0, nerr = 0;

    // Reference model: FIFO contents as a queue plus the two sticky flags
    logic [7:0] q[$];
    bit         m_ovf = 0, m_udf = 0;

    multi_push_multi_pop_fifo_v2 #(
        .W(W), .D(D), .NI(NI), .NO(NO), .AF_LEVEL(4), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .can_push(can_push),
        .can_pop(can_pop), .count(count), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    wire [12:0] act_status = {count, can_push, can_pop, pop_valid,
                              almost_full, almost_empty, overflow, underflow};

    function automatic logic [12:0] exp_status();
        int n   = q.size();
        int cp  = (D - n < NI) ? D - n : NI;
        int cpo = (n < NO) ? n : NO;
        return {3'(n), 2'(cp), 2'(cpo), n > 1, n > 0, n >= 4, n <= 1, m_ovf, m_udf};
    endfunction

    // Apply one cycle of requests from the spec's rules on a plain queue
    task automatic model_step(input int np, input logic [23:0] d, input int npop,
                              input bit fl, input bit ec);
        bit ovs = 0, uds = 0;
        if (fl) begin
            q.delete();
        end else begin
            int cp  = (D - q.size() < NI) ? D - q.size() : NI;
            int cpo = (q.size() < NO) ? q.size() : NO;
            int ap  = (np < cp) ? np : cp;
            int apo = (npop < cpo) ? npop : cpo;
            ovs = (np > cp);
            uds = (npop > cpo);
            repeat (apo) void'(q.pop_front());
            for (int i = 0; i < ap; i++) q.push_back(d[i*8 +: 8]);
        end
        m_ovf = ovs ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_udf = uds ? 1'b1 : (ec ? 1'b0 : m_udf);
    endtask

    // Drive one clock of requests; returns 1 time unit after the edge
    task automatic cyc(input int np, input logic [23:0] d, input int npop,
                       input bit fl, input bit ec);
        push = 2'(np); push_data = d; pop = 2'(npop); flush = fl; err_clr = ec;
        @(posedge clk);
        model_step(np, d, npop, fl, ec);
        #1;
        push = '0; pop = '0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", count); end
        nvec++; if (can_push !== 2'd3) begin nerr++; $display("FAIL reset_can_push got %0d exp 3", can_push); end
        nvec++; if (can_pop !== 2'd0) begin nerr++; $display("FAIL reset_can_pop got %0d exp 0", can_pop); end
        nvec++; if (pop_valid !== 2'b00) begin nerr++; $display("FAIL reset_pop_valid got %b exp 00", pop_valid); end
        nvec++; if ({almost_empty, almost_full, overflow, underflow} !== 4'b1000) begin
            nerr++; $display("FAIL reset_flags got %b exp 1000", {almost_empty, almost_full, overflow, underflow});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_fill_overflow();
        cyc(3, 24'h121110, 0, 0, 0);
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL fill_count1 got %0d exp 3", count); end
        nvec++; if (can_push !== 2'd2) begin nerr++; $display("FAIL fill_can_push1 got %0d exp 2", can_push); end
        cyc(3, 24'h151413, 0, 0, 0);
        nvec++; if (count !== 3'd5) begin nerr++; $display("FAIL fill_count2 got %0d exp 5", count); end
        nvec++; if (can_push !== 2'd0) begin nerr++; $display("FAIL fill_can_push2 got %0d exp 0", can_push); end
        nvec++; if ({overflow, almost_full} !== 2'b11) begin
            nerr++; $display("FAIL fill_ovf_af got %b exp 11", {overflow, almost_full});
        end
    endtask

    task automatic test_wrap();
        nvec++; if (pop_data !== 16'h1110) begin nerr++; $display("FAIL wrap_pop1 got %h exp 1110", pop_data); end
        cyc(0, 24'h0, 2, 0, 0);
        nvec++; if (pop_data !== 16'h1312) begin nerr++; $display("FAIL wrap_pop2 got %h exp 1312", pop_data); end
        cyc(2, 24'h002120, 2, 0, 0);
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL wrap_count got %0d exp 3", count); end
        nvec++; if (pop_data !== 16'h2014) begin nerr++; $display("FAIL wrap_pop3 got %h exp 2014", pop_data); end
        cyc(0, 24'h0, 2, 0, 0);
        nvec++; if (pop_data[0] !== 8'h21) begin nerr++; $display("FAIL wrap_pop4 got %h exp 21", pop_data[0]); end
        nvec++; if (pop_valid !== 2'b01) begin nerr++; $display("FAIL wrap_valid got %b exp 01", pop_valid); end
        cyc(0, 24'h0, 1, 0, 0);
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL wrap_empty got %0d exp 0", count); end
    endtask

    task automatic test_push_underflow();
        cyc(0, 24'h0, 0, 0, 1);
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL uf_errclr got %b exp 0", overflow); end
        cyc(1, 24'h0000AA, 0, 0, 0);
        nvec++; if (pop_data[0] !== 8'hAA) begin nerr++; $display("FAIL uf_head got %h exp aa", pop_data[0]); end
        cyc(2, 24'h003130, 2, 0, 0);
        nvec++; if (underflow !== 1'b1) begin nerr++; $display("FAIL uf_flag got %b exp 1", underflow); end
        nvec++; if (count !== 3'd2) begin nerr++; $display("FAIL uf_count got %0d exp 2", count); end
        nvec++; if ({pop_valid, pop_data} !== 18'h33130) begin
            nerr++; $display("FAIL uf_data got %h exp 33130", {pop_valid, pop_data});
        end
    endtask

    task automatic test_flush();
        cyc(0, 24'h0, 0, 0, 1);
        cyc(3, 24'h424140, 1, 0, 0);
        cyc(2, 24'h004443, 1, 0, 0);
        nvec++; if ({count, overflow} !== {3'd4, 1'b1}) begin
            nerr++; $display("FAIL flush_setup got %0d/%b exp 4/1", count, overflow);
        end
        cyc(3, 24'h555555, 0, 1, 0);
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL flush_count got %0d exp 0", count); end
        nvec++; if (can_push !== 2'd3) begin nerr++; $display("FAIL flush_can_push got %0d exp 3", can_push); end
        nvec++; if ({overflow, underflow} !== 2'b10) begin
            nerr++; $display("FAIL flush_flags got %b exp 10", {overflow, underflow});
        end
        cyc(0, 24'h0, 0, 0, 1);
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL flush_errclr got %b exp 0", overflow); end
    endtask

    task automatic test_async_reset();
        cyc(3, 24'h525150, 0, 0, 0);
        nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL arst_pre got %0d exp 3", count); end
        #2 rst = 1'b1;
        #1;
        q.delete(); m_ovf = 0; m_udf = 0;
        nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL arst_count got %0d exp 0", count); end
        nvec++; if ({can_push, pop_valid} !== 4'b1100) begin
            nerr++; $display("FAIL arst_outs got %b exp 1100", {can_push, pop_valid});
        end
        #1 rst = 1'b0;
        cyc(1, 24'h000055, 0, 0, 0);
        nvec++; if ({pop_valid, pop_data[0]} !== 10'h155) begin
            nerr++; $display("FAIL arst_push got %h exp 155", {pop_valid, pop_data[0]});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            int np   = $urandom_range(0, 3);
            int npop = $urandom_range(0, 2);
            bit fl   = ($urandom_range(0, 15) == 0);
            bit ec   = ($urandom_range(0, 7) == 0);
            logic [23:0] d = 24'($urandom);
            for (int j = 0; j < NO; j++) begin
                if (j < q.size()) begin
                    nvec++;
                    if (pop_data[j] !== q[j]) begin
                        nerr++; $display("FAIL rand_data%0d cyc %0d got %h exp %h", j, k, pop_data[j], q[j]);
                    end
                end
            end
            cyc(np, d, npop, fl, ec);
            nvec++;
            if (act_status !== exp_status()) begin
                nerr++; $display("FAIL rand_status cyc %0d got %b exp %b", k, act_status, exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_push_underflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
